// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the CPU data bus.
//  - register offsets inside an 8-byte peripheral window
//  - STATUS bit positions of the UART transmitter
//  - UART transmit FSM state encoding
//  - helper that packs the STATUS nibble
package mmio_pkg;

    localparam logic [2:0] UART_TXDATA = 3'h0;
    localparam logic [2:0] UART_STATUS = 3'h4;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Packs the four STATUS flags into their bit positions.
    function automatic logic [3:0] uart_status_bits(
        input logic full,
        input logic empty,
        input logic active,
        input logic ovf
    );
        logic [3:0] bits;
        bits            = 4'b0000;
        bits[ST_FULL]   = full;
        bits[ST_EMPTY]  = empty;
        bits[ST_ACTIVE] = active;
        bits[ST_OVF]    = ovf;
        return bits;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// Ports:
//  clock, reset   rising-edge clock, synchronous active-high reset
//  push, din      write request and data; accepted when not full, or when full
//                 and a pop happens in the same cycle
//  pop            read request; ignored when empty
//  dout           current head entry (combinational)
//  full, empty    occupancy flags
//  count          number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == (AW+1)'(0));
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_pop_s  = pop && !empty_s;
    assign do_push_s = push && (!full_s || do_pop_s);

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console transmitter (8N1, LSB first).
// Register window at BASE_ADDR (8 bytes):
//  +0 TXDATA  W pushes store_data[7:0] into the TX FIFO, R returns 0
//  +4 STATUS  R {ovf, tx_active, empty, full}; W with bit 3 set clears ovf
// Ports:
//  clock, reset   rising-edge clock, synchronous active-high reset
//  load, store    CPU data load/store strobes
//  address        CPU byte address
//  store_data     CPU store data
//  hit            combinational window decode, used by top to mux/mask RAM
//  load_data      registered read data, valid the cycle after load && hit
//  tx             serial line, idles high
//  tx_busy        FIFO holds data or a frame is in progress
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_2000_1000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            hit,
    output logic [XLEN-1:0] load_data,
    output logic            tx,
    output logic            tx_busy
);

    localparam int              CW        = $clog2(CLK_DIV);
    localparam int              CNTW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BAUD_ZERO = CW'(0);
    localparam logic [XLEN-1:0] BASE_S    = BASE_ADDR[XLEN-1:0];

    uart_tx_state_t  state_r;
    logic [CW-1:0]   baud_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            ovf_r;
    logic [XLEN-1:0] load_data_r;

    logic            hit_s;
    logic            txdata_sel_s;
    logic            status_sel_s;
    logic            push_s;
    logic            pop_s;
    logic            ovf_set_s;
    logic            ovf_clr_s;
    logic [XLEN-1:0] read_data_s;
    logic [7:0]      fifo_dout_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CNTW-1:0] fifo_count_s;
    logic            unused_store_bits_s;

    // Upper store bits carry nothing for this byte-wide peripheral.
    assign unused_store_bits_s = &{1'b0, store_data[XLEN-1:8]};

    assign hit_s        = (address[XLEN-1:3] == BASE_S[XLEN-1:3]);
    assign txdata_sel_s = hit_s && (address[2:0] == UART_TXDATA);
    assign status_sel_s = hit_s && (address[2:0] == UART_STATUS);
    assign push_s       = store && txdata_sel_s;
    assign ovf_clr_s    = store && status_sel_s && store_data[ST_OVF];
    // A push into a full FIFO is only lost when no pop frees a slot this cycle.
    assign ovf_set_s    = push_s && fifo_full_s && !pop_s;

    assign hit       = hit_s;
    assign load_data = load_data_r;
    assign tx        = tx_r;
    assign tx_busy   = (fifo_count_s != CNTW'(0)) || (state_r != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (store_data[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Pop the head when a new frame starts: from IDLE, or at the last STOP cycle.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                pop_s = !fifo_empty_s;
            end
            STOP: begin
                if (baud_r == BAUD_ZERO) begin
                    pop_s = !fifo_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Read mux for the register window; unmapped offsets read as zero.
    always_comb begin
        read_data_s = {XLEN{1'b0}};
        case (address[2:0])
            UART_STATUS: begin
                read_data_s = {{(XLEN-4){1'b0}},
                               uart_status_bits(fifo_full_s, fifo_empty_s,
                                                state_r != IDLE, ovf_r)};
            end
            default: begin
                read_data_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Registered read data, held until the next load that hits the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_data_r <= {XLEN{1'b0}};
        end else if (load && hit_s) begin
            load_data_r <= read_data_s;
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    // Transmit FSM; tx only moves on a baud terminal count or on IDLE->START.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= START;
                        shift_r <= fifo_dout_s;
                        baud_r  <= BAUD_LAST;
                        tx_r    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_r == BAUD_ZERO) begin
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                        bit_idx_r <= 3'd0;
                        baud_r    <= BAUD_LAST;
                    end else begin
                        baud_r <= baud_r - CW'(1);
                    end
                end
                DATA: begin
                    if (baud_r == BAUD_ZERO) begin
                        baud_r <= BAUD_LAST;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r - CW'(1);
                    end
                end
                STOP: begin
                    if (baud_r == BAUD_ZERO) begin
                        // Chain straight into the next start bit when data waits.
                        if (!fifo_empty_s) begin
                            state_r <= START;
                            shift_r <= fifo_dout_s;
                            baud_r  <= BAUD_LAST;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= BAUD_ZERO;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule
